// File: rtl/adc_spi_pkg.sv
// Shared frame layout, FSM encoding and ADC register map for the 3-wire ADC configuration master.
package adc_spi_pkg;

    localparam int unsigned FRAME_W  = 24;
    localparam int unsigned ADDR_W   = 13;
    localparam int unsigned DATA_W   = 8;

    localparam int unsigned RW_BIT   = 23;
    localparam int unsigned W_MSB    = 22;
    localparam int unsigned W_LSB    = 21;
    localparam int unsigned ADDR_MSB = 20;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    localparam logic [ADDR_W-1:0] ADC_REG_CONFIG      = 13'h000;
    localparam logic [ADDR_W-1:0] ADC_REG_TRANSFER    = 13'h0FF;
    localparam logic [ADDR_W-1:0] ADC_REG_OUTPUT_MODE = 13'h014;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StGap
    } state_e;

    // Single-byte transfer (W1:W0 = 00); the data field is zero for reads.
    function automatic logic [FRAME_W-1:0] build_frame(input logic              rw,
                                                       input logic [ADDR_W-1:0] addr,
                                                       input logic [DATA_W-1:0] data);
        logic [FRAME_W-1:0] f;
        f                    = '0;
        f[RW_BIT]            = rw;
        f[W_MSB:W_LSB]       = 2'b00;
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[DATA_MSB:DATA_LSB] = rw ? '0 : data;
        return f;
    endfunction

endpackage

// File: rtl/adc_spi_tick.sv
// SCLK half-period divider: one-cycle rise/fall strobes every CLK_DIV cycles while enabled.
module adc_spi_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            half_q, half_d;
    logic            wrap;

    always_comb begin
        wrap   = en_i && (cnt_q == CntLast);
        cnt_d  = cnt_q;
        half_d = half_q;
        if (!en_i) begin
            // Restart at phase 0 so every frame begins with a full low half-period.
            cnt_d  = '0;
            half_d = 1'b0;
        end else if (wrap) begin
            cnt_d  = '0;
            half_d = !half_q;
        end else begin
            cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            half_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
        end
    end

    assign sclk_rise_o = wrap && !half_q;
    assign sclk_fall_o = wrap && half_q;

endmodule

// File: rtl/adc_spi_config.sv
// 3-wire SPI master issuing single-byte 24-bit ADC register frames.
// Define ADC_SPI_READBACK_EN to execute reads; otherwise reads are rejected with rsp_err.
module adc_spi_config
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic              main_clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              csb_n,
    output logic              sclk,
    output logic              sdio_out,
    output logic              sdio_oe,
    input  logic              sdio_in
);

`ifdef ADC_SPI_READBACK_EN
    localparam logic ReadbackEn = 1'b1;
`else
    localparam logic ReadbackEn = 1'b0;
`endif

    localparam int unsigned PhMax = (CS_SETUP > CS_HOLD) ?
                                    ((CS_SETUP > CS_IDLE) ? CS_SETUP : CS_IDLE) :
                                    ((CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE);
    localparam int unsigned PhW = (PhMax > 1) ? $clog2(PhMax) : 1;
    localparam logic [PhW-1:0] SetupLoad = PhW'(CS_SETUP - 1);
    localparam logic [PhW-1:0] HoldLoad  = PhW'(CS_HOLD - 1);
    // The rsp_valid cycle is the first of the CS_IDLE high cycles, so GAP covers the rest.
    localparam logic [PhW-1:0] GapLoad   = PhW'(CS_IDLE - 2);

    state_e              state_q, state_d;
    logic [PhW-1:0]      phase_q, phase_d;
    logic [4:0]          bit_q, bit_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rw_q, rw_d;
    logic                sclk_q, sclk_d;
    logic                oe_q, oe_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic                sclk_rise, sclk_fall;
    logic                cs_active;

    adc_spi_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i       (main_clk),
        .rst_i       (rst),
        .en_i        (state_q == StShift),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        frame_d     = frame_q;
        rdata_d     = rdata_q;
        rw_d        = rw_q;
        sclk_d      = sclk_q;
        oe_d        = oe_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    rw_d    = cmd_rw;
                    rdata_d = '0;
                    bit_d   = '0;
                    if (cmd_rw && !ReadbackEn) begin
                        state_d     = StGap;
                        phase_d     = '0;
                        frame_d     = '0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = StSetup;
                        phase_d = SetupLoad;
                        frame_d = build_frame(cmd_rw, cmd_addr, cmd_wdata);
                        oe_d    = 1'b1;
                    end
                end
            end
            StSetup: begin
                if (phase_q == '0) state_d = StShift;
                else               phase_d = phase_q - 1'b1;
            end
            StShift: begin
                if (sclk_rise) begin
                    sclk_d = 1'b1;
                    if (rw_q && bit_q >= 5'd16) rdata_d = {rdata_q[DATA_W-2:0], sdio_in};
                end
                if (sclk_fall) begin
                    sclk_d  = 1'b0;
                    frame_d = {frame_q[FRAME_W-2:0], 1'b0};
                    // Turn the line around after the 16 command bits of a read.
                    if (rw_q && bit_q == 5'd15) oe_d = 1'b0;
                    if (bit_q == 5'd23) begin
                        state_d = StHold;
                        phase_d = HoldLoad;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end
            end
            StHold: begin
                if (phase_q == '0) begin
                    oe_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    if (CS_IDLE > 1) begin
                        state_d = StGap;
                        phase_d = GapLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            StGap: begin
                if (phase_q == '0) state_d = StIdle;
                else               phase_d = phase_q - 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge main_clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            phase_q     <= '0;
            bit_q       <= '0;
            frame_q     <= '0;
            rdata_q     <= '0;
            rw_q        <= 1'b0;
            sclk_q      <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            frame_q     <= frame_d;
            rdata_q     <= rdata_d;
            rw_q        <= rw_d;
            sclk_q      <= sclk_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cs_active = (state_q == StSetup) || (state_q == StShift) || (state_q == StHold);
    assign cmd_ready = (state_q == StIdle);
    assign busy      = !cmd_ready;
    assign csb_n     = !cs_active;
    assign sclk      = sclk_q;
    assign sdio_out  = cs_active && frame_q[FRAME_W-1];
    assign sdio_oe   = oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = (rsp_valid_q && rw_q) ? rdata_q : '0;

endmodule

// File: tb/tb_adc_spi_config.sv
// Directed bench for adc_spi_config: default-timing instance plus a CLK_DIV=1 fast instance.
module tb_adc_spi_config;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1;
    logic        cmd_rw;
    logic [12:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        sdio_in = 1'b0;

    logic        cmd_ready0, rsp_valid0, rsp_err0, busy0, csb_n0, sclk0, sdio_out0, sdio_oe0;
    logic [7:0]  rsp_rdata0;
    logic        cmd_ready1, rsp_valid1, rsp_err1, busy1, csb_n1, sclk1, sdio_out1, sdio_oe1;
    logic [7:0]  rsp_rdata1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adc_spi_config dut (
        .main_clk  (clk),
        .rst       (rst),
        .cmd_valid (v0),
        .cmd_ready (cmd_ready0),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid0),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0),
        .busy      (busy0),
        .csb_n     (csb_n0),
        .sclk      (sclk0),
        .sdio_out  (sdio_out0),
        .sdio_oe   (sdio_oe0),
        .sdio_in   (sdio_in)
    );

    adc_spi_config #(
        .CLK_DIV  (1),
        .CS_SETUP (1),
        .CS_HOLD  (1),
        .CS_IDLE  (1)
    ) dut_fast (
        .main_clk  (clk),
        .rst       (rst),
        .cmd_valid (v1),
        .cmd_ready (cmd_ready1),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid1),
        .rsp_rdata (rsp_rdata1),
        .rsp_err   (rsp_err1),
        .busy      (busy1),
        .csb_n     (csb_n1),
        .sclk      (sclk1),
        .sdio_out  (sdio_out1),
        .sdio_oe   (sdio_oe1),
        .sdio_in   (sdio_in)
    );

    // ADC model: returns adc_byte MSB first, changing on the falls after rising edges 16..23.
    logic [7:0] adc_byte = 8'h3C;
    int         fcnt = 0;
    always @(negedge sclk0 or posedge csb_n0) begin
        if (csb_n0) begin
            fcnt    <= 0;
            sdio_in <= 1'b0;
        end else begin
            fcnt <= fcnt + 1;
            if (fcnt >= 15 && fcnt <= 22) sdio_in <= adc_byte[22-fcnt];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Results of the last run0 call.
    int          cyc, rsp_cyc, ready_cyc, n_rsp, rises, oe_drop_at;
    logic [23:0] bits;
    logic [7:0]  got_rdata;
    logic        got_err, csb_seen_low, prev_sclk;
    logic        c1_csb, c1_oe, c1_ready, c1_busy, c1_out;

    // Clocks the accept edge with v0 already set, then follows the frame on dut.
    task automatic run0(input int max_cyc, input int stop_at_rise);
        cyc = 0; rsp_cyc = -1; ready_cyc = -1; n_rsp = 0; rises = 0; oe_drop_at = -1;
        bits = '0; got_rdata = 8'hxx; got_err = 1'bx; csb_seen_low = 1'b0; prev_sclk = sclk0;
        while (cyc < max_cyc) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                v0 = 1'b0;
                c1_csb = csb_n0; c1_oe = sdio_oe0; c1_ready = cmd_ready0;
                c1_busy = busy0; c1_out = sdio_out0;
            end
            if (!csb_n0) csb_seen_low = 1'b1;
            if (!prev_sclk && sclk0) begin
                rises++;
                bits = {bits[22:0], sdio_out0};
            end
            prev_sclk = sclk0;
            if (!csb_n0 && !sdio_oe0 && oe_drop_at < 0) oe_drop_at = rises;
            if (rsp_valid0) begin
                n_rsp++;
                if (rsp_cyc < 0) begin
                    rsp_cyc = cyc; got_rdata = rsp_rdata0; got_err = rsp_err0;
                end
            end
            if (stop_at_rise > 0 && rises == stop_at_rise) break;
            if (cmd_ready0 && rsp_cyc >= 0) begin
                ready_cyc = cyc;
                break;
            end
        end
    endtask

    int          starts, hi_run, gap, pulses, f_rsp, f_r1, f_r2, f_rises;
    logic        prev_csb, prev1;
    logic [23:0] f_bits;

    initial begin
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
        cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        #1;
        chk("reset csb_n", csb_n0, 1'b1);
        chk("reset sclk", sclk0, 1'b0);
        chk("reset sdio_oe/out", {sdio_oe0, sdio_out0}, 2'b00);
        chk("reset ready/busy", {cmd_ready0, busy0}, 2'b10);
        chk("reset rsp", {rsp_valid0, rsp_err0, rsp_rdata0}, 10'h000);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Single write to the output-mode register.
        cmd_rw = 1'b0; cmd_addr = 13'h014; cmd_wdata = 8'hA5; v0 = 1'b1;
        run0(400, 0);
        chk("wr c1 csb_n", c1_csb, 1'b0);
        chk("wr c1 sdio_oe", c1_oe, 1'b1);
        chk("wr c1 sdio_out bit23", c1_out, 1'b0);
        chk("wr c1 ready/busy", {c1_ready, c1_busy}, 2'b01);
        chk("wr rising edges", rises, 24);
        chk("wr frame bits", bits, 24'h0014A5);
        chk("wr rsp cycle", rsp_cyc, 197);
        chk("wr rsp pulses", n_rsp, 1);
        chk("wr rsp_err", got_err, 1'b0);
        chk("wr rsp_rdata", got_rdata, 8'h00);
        chk("wr oe never drops", oe_drop_at, -1);
        chk("wr ready returned", ready_cyc > 0, 1'b1);
        repeat (2) tick();

        cmd_rw = 1'b1; cmd_addr = 13'h001; cmd_wdata = 8'hFF; v0 = 1'b1;
`ifdef ADC_SPI_READBACK_EN
        run0(400, 0);
        chk("rd c1 sdio_out bit23", c1_out, 1'b1);
        chk("rd oe drop after edge", oe_drop_at, 16);
        chk("rd frame bits 23..8", bits[23:8], 16'h8001);
        chk("rd rsp cycle", rsp_cyc, 197);
        chk("rd rsp_rdata", got_rdata, 8'h3C);
        chk("rd rsp_err", got_err, 1'b0);
`else
        run0(20, 0);
        chk("rd-dis csb never low", csb_seen_low, 1'b0);
        chk("rd-dis c1 sdio_oe", c1_oe, 1'b0);
        chk("rd-dis c1 ready", c1_ready, 1'b0);
        chk("rd-dis rsp cycle", rsp_cyc, 1);
        chk("rd-dis rsp_err", got_err, 1'b1);
        chk("rd-dis rsp_rdata", got_rdata, 8'h00);
        chk("rd-dis ready cycle", ready_cyc, 2);
        chk("rd-dis rsp pulses", n_rsp, 1);
`endif
        repeat (2) tick();

        // Two writes with cmd_valid held: csb_n high time between frames.
        cmd_rw = 1'b0; cmd_addr = 13'h0FF; cmd_wdata = 8'h01; v0 = 1'b1;
        starts = 0; hi_run = 0; gap = -1; pulses = 0; prev_csb = csb_n0;
        for (int c = 0; c < 700; c++) begin
            tick();
            if (prev_csb && !csb_n0) begin
                starts++;
                if (starts == 2) begin
                    v0 = 1'b0;
                    gap = hi_run;
                end
            end
            if (csb_n0) hi_run++;
            else        hi_run = 0;
            if (rsp_valid0) pulses++;
            prev_csb = csb_n0;
            if (starts == 2 && pulses == 2 && cmd_ready0) break;
        end
        v0 = 1'b0;
        chk("b2b frame starts", starts, 2);
        chk("b2b csb_n high gap", gap, 4);
        chk("b2b rsp pulses", pulses, 2);
        repeat (2) tick();

        // Reset at rising edge 10 aborts the frame with no response.
        cmd_rw = 1'b0; cmd_addr = 13'h000; cmd_wdata = 8'h3C; v0 = 1'b1;
        run0(400, 10);
        chk("abort reached edge 10", rises, 10);
        rst = 1'b1;
        #1;
        chk("abort csb_n", csb_n0, 1'b1);
        chk("abort sclk", sclk0, 1'b0);
        chk("abort sdio_oe", sdio_oe0, 1'b0);
        chk("abort ready/busy", {cmd_ready0, busy0}, 2'b10);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 250; c++) begin
            tick();
            if (rsp_valid0) pulses++;
        end
        chk("abort no rsp", pulses, 0);
        cmd_rw = 1'b0; cmd_addr = 13'h014; cmd_wdata = 8'h5A; v0 = 1'b1;
        run0(400, 0);
        chk("post-abort rsp cycle", rsp_cyc, 197);
        chk("post-abort frame bits", bits, 24'h00145A);
        repeat (2) tick();

        // Minimum timing instance.
        cmd_rw = 1'b0; cmd_addr = 13'h0FF; cmd_wdata = 8'h5A; v1 = 1'b1;
        f_rsp = -1; f_r1 = -1; f_r2 = -1; f_rises = 0; f_bits = '0; prev1 = sclk1;
        for (int c = 1; c <= 120; c++) begin
            tick();
            if (c == 1) v1 = 1'b0;
            if (!prev1 && sclk1) begin
                f_rises++;
                f_bits = {f_bits[22:0], sdio_out1};
                if (f_rises == 1) f_r1 = c;
                if (f_rises == 2) f_r2 = c;
            end
            prev1 = sclk1;
            if (rsp_valid1) begin
                f_rsp = c;
                break;
            end
        end
        chk("fast rsp cycle", f_rsp, 51);
        chk("fast sclk period", f_r2 - f_r1, 2);
        chk("fast rising edges", f_rises, 24);
        chk("fast frame bits", f_bits, 24'h00FF5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
